// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the integer functional units on the CDB
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int FU_TAG_W = 4;

  // Common CDB payload; the MUL/DIV units will broadcast the same shape.
  typedef struct packed {
    logic [FU_TAG_W-1:0] tag;
    logic [31:0]         data;
    logic                cout;
    logic                ovf;
  } fu_result_t;

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/doublingCLA_32.sv
// rtl/doublingCLA_32.sv - 32-bit carry-lookahead adder built on a doubling-span prefix tree
module doublingCLA_32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  logic [31:0] hp;
  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] g_n;
  logic [31:0] p_n;
  logic [32:0] c;

  // Each level doubles the span of the group generate/propagate terms: 1, 2, 4, 8, 16.
  always_comb begin
    hp  = a_i ^ b_i;
    g   = a_i & b_i;
    p   = hp;
    g_n = g;
    p_n = p;
    for (int k = 0; k < 5; k++) begin
      g_n = g;
      p_n = p;
      for (int i = (1 << k); i < 32; i++) begin
        g_n[i] = g[i] | (p[i] & g[i-(1 << k)]);
        p_n[i] = p[i] & p[i-(1 << k)];
      end
      g = g_n;
      p = p_n;
    end
    c[0] = cin_i;
    for (int i = 0; i < 32; i++) begin
      c[i+1] = g[i] | (p[i] & cin_i);
    end
  end

  assign sum_o  = hp ^ c[31:0];
  assign cout_o = c[32];

endmodule

// File: rtl/add_sub_fu.sv
// rtl/add_sub_fu.sv - elastic add/subtract functional unit holding each result until the CDB grants it
module add_sub_fu
  import alu_pkg::*;
#(
  parameter int TAG_W  = FU_TAG_W,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             cdb_req,
  input  logic             cdb_grant,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [31:0]      cdb_data,
  output logic             cdb_cout,
  output logic             cdb_ovf
);

  // Number of result-holding stages; the last one is the CDB output register.
  localparam int NR = (STAGES > 1) ? STAGES - 1 : 1;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    logic             cout;
    logic             ovf;
  } res_t;

  logic             src_vld;
  logic             src_op;
  logic [31:0]      src_a;
  logic [31:0]      src_b;
  logic [TAG_W-1:0] src_tag;
  logic [31:0]      b_eff;
  logic [31:0]      sum;
  logic             sum_cout;
  res_t             new_res;

  res_t          res_q [NR];
  res_t          res_d [NR];
  logic [NR-1:0] rv_q;
  logic [NR-1:0] rv_d;
  logic [NR:0]   rdy;
  logic [NR:0]   chain_v;
  res_t          chain_r [NR+1];

  always_comb begin
    rdy[NR] = cdb_grant;
    for (int i = NR - 1; i >= 0; i--) begin
      rdy[i] = ~rv_q[i] | rdy[i+1];
    end
  end

  if (STAGES > 1) begin : g_opnd
    logic             ov_q, ov_d;
    logic             op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    assign in_ready = ~ov_q | rdy[0];

    always_comb begin
      ov_d  = ov_q;
      op_d  = op_q;
      a_d   = a_q;
      b_d   = b_q;
      tag_d = tag_q;
      if (in_ready) begin
        ov_d = in_valid;
        if (in_valid) begin
          op_d  = in_op;
          a_d   = in_a;
          b_d   = in_b;
          tag_d = in_tag;
        end
      end
      if (flush) ov_d = 1'b0;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        ov_q  <= 1'b0;
        op_q  <= OP_ADD;
        a_q   <= '0;
        b_q   <= '0;
        tag_q <= '0;
      end else begin
        ov_q  <= ov_d;
        op_q  <= op_d;
        a_q   <= a_d;
        b_q   <= b_d;
        tag_q <= tag_d;
      end
    end

    assign src_vld = ov_q;
    assign src_op  = op_q;
    assign src_a   = a_q;
    assign src_b   = b_q;
    assign src_tag = tag_q;
  end else begin : g_direct
    assign in_ready = rdy[0];
    assign src_vld  = in_valid;
    assign src_op   = in_op;
    assign src_a    = in_a;
    assign src_b    = in_b;
    assign src_tag  = in_tag;
  end

  // Subtraction is A + ~B + 1, so the op bit doubles as the carry-in.
  assign b_eff = (src_op == OP_SUB) ? ~src_b : src_b;

  doublingCLA_32 u_cla (
    .a_i    (src_a),
    .b_i    (b_eff),
    .cin_i  (src_op),
    .sum_o  (sum),
    .cout_o (sum_cout)
  );

  always_comb begin
    new_res.tag  = src_tag;
    new_res.data = sum;
    new_res.cout = sum_cout;
    new_res.ovf  = signed_ovf(src_a[31], b_eff[31], sum[31]);
  end

  always_comb begin
    chain_v[0] = src_vld;
    chain_r[0] = new_res;
    for (int i = 0; i < NR; i++) begin
      chain_v[i+1] = rv_q[i];
      chain_r[i+1] = res_q[i];
    end
    for (int i = 0; i < NR; i++) begin
      rv_d[i]  = rv_q[i];
      res_d[i] = res_q[i];
      if (rdy[i]) begin
        rv_d[i] = chain_v[i];
        // Payload only moves with a valid op so idle outputs keep their last value.
        if (chain_v[i]) res_d[i] = chain_r[i];
      end
    end
    if (flush) rv_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rv_q <= '0;
      for (int i = 0; i < NR; i++) res_q[i] <= '0;
    end else begin
      rv_q <= rv_d;
      for (int i = 0; i < NR; i++) res_q[i] <= res_d[i];
    end
  end

  assign cdb_req  = rv_q[NR-1];
  assign cdb_tag  = res_q[NR-1].tag;
  assign cdb_data = res_q[NR-1].data;
  assign cdb_cout = res_q[NR-1].cout;
  assign cdb_ovf  = res_q[NR-1].ovf;

endmodule

// File: tb/tb_add_sub_fu.sv
// tb/tb_add_sub_fu.sv - randomized scoreboard bench for add_sub_fu
module tb_add_sub_fu;

  localparam int TAG_W  = 4;
  localparam int STAGES = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_op;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             cdb_req;
  logic             cdb_grant;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             cdb_cout;
  logic             cdb_ovf;

  always #5 clk = ~clk;

  add_sub_fu #(.TAG_W(TAG_W), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .flush     (flush),
    .cdb_req   (cdb_req),
    .cdb_grant (cdb_grant),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_cout  (cdb_cout),
    .cdb_ovf   (cdb_ovf)
  );

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    logic             cout;
    logic             ovf;
  } rec_t;

  rec_t exp_q[$];
  rec_t bc_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  function automatic rec_t model(logic op, logic [31:0] a, logic [31:0] b, logic [TAG_W-1:0] tag);
    rec_t   r;
    longint sa;
    longint sb;
    longint sr;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    r.tag = tag;
    if (op) begin
      r.data = a - b;
      r.cout = (a >= b);
      sr     = sa - sb;
    end else begin
      r.data = a + b;
      r.cout = ((longint'(a) + longint'(b)) > 64'sd4294967295);
      sr     = sa + sb;
    end
    r.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return r;
  endfunction

  // Scoreboard: every granted broadcast must match the oldest accepted op.
  always @(negedge clk) begin : mon
    rec_t got;
    rec_t e;
    if (mon_en) begin
      if (!rst_n) begin
        exp_q.delete();
      end else begin
        if (cdb_req && cdb_grant) begin
          got = '{cdb_tag, cdb_data, cdb_cout, cdb_ovf};
          bc_q.push_back(got);
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_broadcast got tag=%0d data=%h required no broadcast", got.tag, got.data);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              n_bad++;
              $display("FAIL broadcast got tag=%0d data=%h c=%b v=%b required tag=%0d data=%h c=%b v=%b",
                       got.tag, got.data, got.cout, got.ovf, e.tag, e.data, e.cout, e.ovf);
            end
          end
        end
        if (flush) exp_q.delete();
        else if (in_valid && in_ready) exp_q.push_back(model(in_op, in_a, in_b, in_tag));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int hits;
    rst_n = 1'b0;
    step();
    step();
    @(negedge clk);
    n_cmp += 6;
    if (cdb_req !== 1'b0)   begin n_bad++; $display("FAIL rst_req got %b required 0", cdb_req); end
    if (cdb_data !== 32'd0) begin n_bad++; $display("FAIL rst_data got %h required 0", cdb_data); end
    if (cdb_tag !== 4'd0)   begin n_bad++; $display("FAIL rst_tag got %0d required 0", cdb_tag); end
    if (cdb_cout !== 1'b0)  begin n_bad++; $display("FAIL rst_cout got %b required 0", cdb_cout); end
    if (cdb_ovf !== 1'b0)   begin n_bad++; $display("FAIL rst_ovf got %b required 0", cdb_ovf); end
    if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL rst_ready got %b required 1", in_ready); end
    step();
    rst_n     = 1'b1;
    cdb_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_op    = 1'($urandom);
      in_a     = $urandom;
      in_b     = $urandom;
      in_tag   = 4'(9 + i);
      step();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp += 3;
    if (cdb_req !== 1'b0)   begin n_bad++; $display("FAIL midrst_req got %b required 0", cdb_req); end
    if (cdb_data !== 32'd0) begin n_bad++; $display("FAIL midrst_data got %h required 0", cdb_data); end
    if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL midrst_ready got %b required 1", in_ready); end
    step();
    bc_q.delete();
    cdb_grant = 1'b1;
    repeat (6) step();
    hits = 0;
    foreach (bc_q[k]) if (bc_q[k].tag >= 4'd9 && bc_q[k].tag <= 4'd11) hits++;
    n_cmp++;
    if (hits != 0) begin n_bad++; $display("FAIL midrst_ghost got %0d broadcasts required 0", hits); end
  endtask

  task automatic test_add_stream();
    logic [31:0] av [3] = '{32'd2, 32'd10, 32'd127};
    logic [31:0] bv [3] = '{32'd5, 32'd21, 32'd200};
    logic [31:0] dv [3] = '{32'd7, 32'd31, 32'd327};
    bit          exp_req;
    cdb_grant = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 3);
      in_op    = 1'b0;
      in_a     = (i < 3) ? av[i] : 32'd0;
      in_b     = (i < 3) ? bv[i] : 32'd0;
      in_tag   = 4'(i + 1);
      @(negedge clk);
      exp_req = (i >= 2 && i <= 4);
      n_cmp++;
      if (cdb_req !== exp_req) begin
        n_bad++; $display("FAIL add_stream_req cycle %0d got %b required %b", i, cdb_req, exp_req);
      end else if (exp_req) begin
        n_cmp++;
        if (cdb_data !== dv[i-2] || cdb_tag !== 4'(i - 1) || cdb_cout !== 1'b0 || cdb_ovf !== 1'b0) begin
          n_bad++;
          $display("FAIL add_stream_data cycle %0d got tag=%0d data=%0d c=%b v=%b required tag=%0d data=%0d c=0 v=0",
                   i, cdb_tag, cdb_data, cdb_cout, cdb_ovf, i - 1, dv[i-2]);
        end
      end
      step();
    end
  endtask

  task automatic test_sub_flags();
    logic        ops [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] av  [5] = '{32'd5, 32'd7, 32'h7FFFFFFF, 32'h80000000, 32'd1147483647};
    logic [31:0] bv  [5] = '{32'd7, 32'd5, 32'd1, 32'd1, 32'd1147483648};
    logic [31:0] dv  [5] = '{32'hFFFFFFFE, 32'd2, 32'h80000000, 32'h7FFFFFFF, 32'd2294967295};
    logic        cv  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        vv  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bc_q.delete();
    cdb_grant = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_op    = ops[i];
      in_a     = av[i];
      in_b     = bv[i];
      in_tag   = 4'(i + 4);
      step();
    end
    in_valid = 1'b0;
    repeat (6) step();
    n_cmp++;
    if (bc_q.size() != 5) begin
      n_bad++; $display("FAIL flags_count got %0d required 5", bc_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (bc_q[i].data !== dv[i] || bc_q[i].cout !== cv[i] || bc_q[i].ovf !== vv[i] || bc_q[i].tag !== 4'(i + 4)) begin
          n_bad++;
          $display("FAIL flags_%0d got data=%h c=%b v=%b tag=%0d required data=%h c=%b v=%b tag=%0d",
                   i, bc_q[i].data, bc_q[i].cout, bc_q[i].ovf, bc_q[i].tag, dv[i], cv[i], vv[i], i + 4);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [TAG_W-1:0] acc[$];
    rec_t             snap;
    rec_t             cur;
    bit               seen;
    logic             last_ready;
    bc_q.delete();
    cdb_grant = 1'b0;
    seen      = 1'b0;
    in_tag    = 4'd8;
    in_op     = 1'($urandom);
    in_a      = $urandom;
    in_b      = $urandom;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      last_ready = in_ready;
      if (cdb_req) begin
        cur = '{cdb_tag, cdb_data, cdb_cout, cdb_ovf};
        if (!seen) begin
          snap = cur;
          seen = 1'b1;
        end else begin
          n_cmp++;
          if (cur !== snap) begin
            n_bad++; $display("FAIL bp_stable cycle %0d got tag=%0d data=%h required tag=%0d data=%h",
                              i, cur.tag, cur.data, snap.tag, snap.data);
          end
        end
      end
      if (in_ready) acc.push_back(in_tag);
      step();
      if (last_ready) begin
        in_tag = in_tag + 4'd1;
        in_op  = 1'($urandom);
        in_a   = $urandom;
        in_b   = $urandom;
      end
    end
    n_cmp += 2;
    if (acc.size() != STAGES) begin n_bad++; $display("FAIL bp_accepted got %0d required %0d", acc.size(), STAGES); end
    if (last_ready !== 1'b0)  begin n_bad++; $display("FAIL bp_ready got %b required 0", last_ready); end
    in_valid  = 1'b0;
    cdb_grant = 1'b1;
    repeat (6) step();
    n_cmp++;
    if (bc_q.size() != acc.size()) begin
      n_bad++; $display("FAIL bp_drain_count got %0d required %0d", bc_q.size(), acc.size());
    end else begin
      foreach (acc[k]) begin
        n_cmp++;
        if (bc_q[k].tag !== acc[k]) begin
          n_bad++; $display("FAIL bp_order idx %0d got tag=%0d required %0d", k, bc_q[k].tag, acc[k]);
        end
      end
    end
  endtask

  task automatic test_flush();
    int n12, n13, n14;
    bc_q.delete();
    cdb_grant = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_op    = 1'($urandom);
      in_a     = $urandom;
      in_b     = $urandom;
      in_tag   = 4'(12 + i);
      step();
    end
    in_tag    = 4'd14;
    flush     = 1'b1;
    cdb_grant = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cdb_req !== 1'b1 || cdb_tag !== 4'd12) begin
      n_bad++; $display("FAIL flush_out got req=%b tag=%0d required req=1 tag=12", cdb_req, cdb_tag);
    end
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp += 2;
    if (cdb_req !== 1'b0)  begin n_bad++; $display("FAIL flush_req got %b required 0", cdb_req); end
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready got %b required 1", in_ready); end
    step();
    repeat (5) step();
    n12 = 0; n13 = 0; n14 = 0;
    foreach (bc_q[k]) begin
      if (bc_q[k].tag == 4'd12) n12++;
      if (bc_q[k].tag == 4'd13) n13++;
      if (bc_q[k].tag == 4'd14) n14++;
    end
    n_cmp++;
    if (n12 != 1 || n13 != 0 || n14 != 0) begin
      n_bad++; $display("FAIL flush_bcast got t12=%0d t13=%0d t14=%0d required 1/0/0", n12, n13, n14);
    end
  endtask

  task automatic test_back_to_back();
    int n_acc;
    int stalls;
    int budget;
    bc_q.delete();
    n_acc     = 0;
    cdb_grant = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_op    = 1'($urandom);
      in_a     = $urandom;
      in_b     = $urandom;
      in_tag   = 4'($urandom);
      step();
      n_acc++;
    end
    cdb_grant = 1'b1;
    in_tag    = 4'($urandom);
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || cdb_req !== 1'b1) begin
      n_bad++; $display("FAIL b2b_full got ready=%b req=%b required 1/1", in_ready, cdb_req);
    end
    if (in_ready) n_acc++;
    step();
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      in_op  = 1'($urandom);
      in_a   = (i % 7 == 0) ? 32'hFFFFFFFF : $urandom;
      in_b   = (i % 5 == 0) ? 32'h80000000 : $urandom;
      in_tag = 4'($urandom);
      @(negedge clk);
      if (!in_ready) stalls++;
      else n_acc++;
      step();
    end
    n_cmp++;
    if (stalls != 0) begin n_bad++; $display("FAIL b2b_stalls got %0d required 0", stalls); end
    for (int i = 0; i < 60; i++) begin
      in_valid  = 1'($urandom);
      cdb_grant = 1'($urandom);
      in_op     = 1'($urandom);
      in_a      = $urandom;
      in_b      = $urandom;
      in_tag    = 4'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) n_acc++;
      step();
    end
    in_valid  = 1'b0;
    cdb_grant = 1'b1;
    budget    = 0;
    while ((exp_q.size() != 0 || cdb_req) && budget < 20) begin
      step();
      budget++;
    end
    n_cmp += 2;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL b2b_drain got %0d pending required 0", exp_q.size()); end
    if (bc_q.size() != n_acc) begin n_bad++; $display("FAIL b2b_total got %0d required %0d", bc_q.size(), n_acc); end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    flush     = 1'b0;
    cdb_grant = 1'b0;
    mon_en    = 1'b1;
    step();
    test_reset();
    test_add_stream();
    test_sub_flags();
    test_backpressure();
    test_flush();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
